mod_dff_sched: RTL and testbench

//  Round-robin scheduler sharing the single bus_t D flip-flop stage (mod_main) among N_REQ requesters.

---
 rtl/mod_dff_sched_if.sv | 22 ++
 rtl/mod_dff_sched.sv | 134 +++++++++++++
 tb/tb_mod_dff_sched.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_dff_sched_if.sv
// Requester and response handshake bundle for the shared flip-flop stage scheduler.
interface mod_dff_sched_if #(
   parameter int unsigned N_REQ = 4
);
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0][11:0] req_data;
   logic [N_REQ-1:0]       req_ready;
   logic                   rsp_valid;
   logic [3:0]             rsp_id;
   logic [11:0]            rsp_data;
   logic                   rsp_ready;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/mod_dff_sched.sv
// Round-robin scheduler time-sharing one enable/data flip-flop stage among N_REQ requesters;
// each word is sent through the stage, checked on return and handed back with its requester id.
module mod_dff_sched #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   mod_dff_sched_if.slave    bus,
   output logic              o_E,
   output logic [11:0]       o_D,
   input  logic [11:0]       i_Q,
   output logic              o_err,
   output logic [CNT_W-1:0]  o_txn_cnt
);

   typedef enum logic [1:0] {StIdle, StLoad, StCapt, StResp} state_e;

   state_e             state_q, state_d;
   logic [3:0]         ptr_q, ptr_d;
   logic [11:0]        sel_data_q, sel_data_d;
   logic [3:0]         sel_id_q, sel_id_d;
   logic [3:0]         rsp_id_q, rsp_id_d;
   logic [11:0]        rsp_data_q, rsp_data_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               win_found;
   logic [3:0]         win_id;
   logic [7:0]         win_word;
   logic [N_REQ-1:0]   req_ready;

   // Search indices above ptr first, then wrap around to 0..ptr.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      win_word  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_found && bus.req_valid[i] && (i > int'(ptr_q))) begin
            win_found = 1'b1;
            win_id    = 4'(i);
            win_word  = bus.req_data[i][7:0];
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_found && bus.req_valid[i] && (i <= int'(ptr_q))) begin
            win_found = 1'b1;
            win_id    = 4'(i);
            win_word  = bus.req_data[i][7:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = (state_q == StIdle) && win_found && (win_id == 4'(i));
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      sel_data_d = sel_data_q;
      sel_id_d   = sel_id_q;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      o_E        = 1'b0;
      o_D        = '0;
      unique case (state_q)
         StIdle: begin
            // Ready is driven from valid, so a winner here is a completed transfer.
            if (win_found) begin
               sel_data_d = {win_id, win_word};
               sel_id_d   = win_id;
               state_d    = StLoad;
            end
         end
         StLoad: begin
            o_E     = 1'b1;
            o_D     = sel_data_q;
            state_d = StCapt;
         end
         StCapt: begin
            rsp_data_d = i_Q;
            rsp_id_d   = i_Q[11:8];
            if (i_Q != sel_data_q) begin
               err_d = 1'b1;
            end
            state_d = StResp;
         end
         StResp: begin
            if (bus.rsp_ready) begin
               ptr_d   = sel_id_q;
               cnt_d   = cnt_q + 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= StIdle;
         ptr_q      <= 4'(N_REQ - 1);
         sel_data_q <= '0;
         sel_id_q   <= '0;
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         sel_data_q <= sel_data_d;
         sel_id_q   <= sel_id_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = (state_q == StResp);
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign o_err         = err_q;
   assign o_txn_cnt     = cnt_q;

endmodule

// File: tb/tb_mod_dff_sched.sv
// Directed bench for mod_dff_sched with a behavioural flip-flop stage and fault injection on Q.
module tb_mod_dff_sched;

   logic        clk;
   logic        rst_n;
   logic        dut_e;
   logic [11:0] dut_d;
   logic [11:0] q_reg;
   logic [11:0] stage_q;
   logic        inj;
   logic        err;
   logic [3:0]  cnt;

   int checks = 0;
   int errors = 0;

   mod_dff_sched_if #(.N_REQ(4)) bus ();

   mod_dff_sched #(
      .N_REQ (4),
      .CNT_W (4)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .bus       (bus),
      .o_E       (dut_e),
      .o_D       (dut_d),
      .i_Q       (stage_q),
      .o_err     (err),
      .o_txn_cnt (cnt)
   );

   // Stage model: captures D when enabled, otherwise clears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_reg <= '0;
      else        q_reg <= dut_e ? dut_d : 12'h000;
   end
   assign stage_q = inj ? 12'h000 : q_reg;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      inj           = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_txn(input int id, input logic [11:0] word);
      logic [11:0] sent;
      sent = {4'(id), word[7:0]};
      cyc();
      bus.req_valid            = 4'(1 << id);
      bus.req_data[id[1:0]]    = word;
      smp();
      check("txn_ready", bus.req_ready, 32'(1 << id));
      cyc();
      bus.req_valid = '0;
      smp();
      check("txn_load_e", dut_e, 1);
      check("txn_load_d", dut_d, sent);
      cyc(); smp();
      check("txn_capt_e", dut_e, 0);
      cyc(); smp();
      check("txn_rsp_valid", bus.rsp_valid, 1);
      check("txn_rsp_id", bus.rsp_id, 32'(id));
      check("txn_rsp_data", bus.rsp_data, sent);
      cyc(); smp();
      check("txn_rsp_done", bus.rsp_valid, 0);
   endtask

   initial begin
      logic [3:0] exp_gnt;
      int         seen;

      rst_n         = 1'b0;
      inj           = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.rsp_ready = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_ready", bus.req_ready, 0);
      check("rst_e", dut_e, 0);
      check("rst_d", dut_d, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_id", bus.rsp_id, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_err", err, 0);
      check("rst_cnt", cnt, 0);
      rst_n = 1'b1;

      // Single request, tag overwritten by requester index
      run_txn(1, 12'hA5C);
      check("single_cnt", cnt, 1);
      check("single_err", err, 0);

      // Round-robin with all requesters valid
      do_reset();
      cyc();
      for (int i = 0; i < 4; i++) bus.req_data[i] = {4'hF, 8'(16 + i)};
      bus.req_valid = 4'hF;
      smp();
      for (int g = 0; g < 8; g++) begin
         exp_gnt = 4'b0001 << (g % 4);
         check("rr_grant", bus.req_ready, exp_gnt);
         repeat (3) begin
            cyc(); smp();
            check("rr_no_grant", bus.req_ready, 0);
         end
         check("rr_rsp_id", bus.rsp_id, 32'(g % 4));
         check("rr_rsp_data", bus.rsp_data, {4'(g % 4), 8'(16 + (g % 4))});
         cyc();
         if (g == 7) bus.req_valid = '0;
         smp();
      end
      check("rr_cnt", cnt, 8);
      check("rr_idle_ready", bus.req_ready, 0);

      // Backpressure in RESP
      do_reset();
      cyc();
      bus.rsp_ready   = 1'b0;
      bus.req_data[0] = 12'h3AB;
      bus.req_data[2] = 12'h3CD;
      bus.req_valid   = 4'b0101;
      smp();
      check("bp_grant0", bus.req_ready, 4'b0001);
      cyc(); smp();
      cyc(); smp();
      for (int k = 0; k < 5; k++) begin
         cyc(); smp();
         check("bp_rsp_valid", bus.rsp_valid, 1);
         check("bp_rsp_data", bus.rsp_data, 12'h0AB);
         check("bp_ready", bus.req_ready, 0);
         check("bp_e", dut_e, 0);
      end
      cyc();
      bus.rsp_ready = 1'b1;
      smp();
      check("bp_release_valid", bus.rsp_valid, 1);
      cyc(); smp();
      check("bp_next_grant", bus.req_ready, 4'b0100);
      check("bp_rsp_cleared", bus.rsp_valid, 0);
      check("bp_cnt", cnt, 1);
      cyc();
      bus.req_valid = '0;
      smp();
      repeat (4) begin cyc(); smp(); end
      check("bp_cnt2", cnt, 2);

      // Error injection on the returned word
      do_reset();
      cyc();
      bus.req_data[2] = 12'h2FF;
      bus.req_valid   = 4'b0100;
      smp();
      check("err_grant", bus.req_ready, 4'b0100);
      cyc();
      bus.req_valid = '0;
      smp();
      check("err_load_d", dut_d, 12'h2FF);
      cyc();
      inj = 1'b1;
      smp();
      cyc();
      inj = 1'b0;
      smp();
      check("err_set", err, 1);
      check("err_rsp_data", bus.rsp_data, 0);
      cyc(); smp();
      run_txn(1, 12'h077);
      check("err_sticky", err, 1);
      run_txn(3, 12'h0E1);
      check("err_sticky2", err, 1);
      do_reset();
      check("err_cleared", err, 0);

      // Counter wrap at 4 bits
      for (int k = 0; k < 17; k++) run_txn(k % 4, {4'h0, 8'(k * 7)});
      check("wrap_cnt", cnt, 1);

      // Asynchronous reset during LOAD
      do_reset();
      run_txn(2, 12'h055);
      cyc();
      bus.req_data[0] = 12'h0C3;
      bus.req_valid   = 4'b0001;
      smp();
      check("mid_grant", bus.req_ready, 4'b0001);
      cyc();
      bus.req_valid = '0;
      smp();
      check("mid_load_e", dut_e, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_e", dut_e, 0);
      check("mid_rst_d", dut_d, 0);
      check("mid_rst_cnt", cnt, 0);
      check("mid_rst_rsp_valid", bus.rsp_valid, 0);
      check("mid_rst_ready", bus.req_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      repeat (6) begin
         cyc(); smp();
         if (bus.rsp_valid) seen++;
      end
      check("mid_no_rsp", seen, 0);
      cyc();
      bus.req_valid = 4'hF;
      smp();
      check("mid_next_grant", bus.req_ready, 4'b0001);
      cyc();
      bus.req_valid = '0;
      smp();
      repeat (4) begin cyc(); smp(); end
      check("mid_final_cnt", cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
